gem_trig_frame_gen: RTL

- Upstream frame generator for the GEM trigger optical links.
- Runs at 160 MHz and latches one BX of cluster data (two 56-bit link payloads plus flags) on a BX strobe.
- Serialises each link payload into a 4-word 8b/10b frame: 16-bit words with charisk, which feed the transceiver wrapper directly.
- Inserts a frame-start K-character that encodes BC0, resync and overflow, and detects strobe misalignment.

---
 rtl/gem_link_pkg.sv | 44 ++++
 rtl/gem_frame_word_mux.sv | 29 ++
 rtl/gem_trig_frame_gen.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/gem_link_pkg.sv
// Shared constants and types for the GEM trigger link frame generator.
// Provides the 8b/10b K-characters, frame geometry, the frame-phase
// enum and the K-character priority selector.
package gem_link_pkg;

  localparam int unsigned PAYLOAD_W   = 56;
  localparam int unsigned FRAME_WORDS = 4;
  localparam int unsigned PHASE_W     = $clog2(FRAME_WORDS);
  localparam int unsigned WORD_W      = 16;
  localparam int unsigned ISK_W       = 2;
  localparam int unsigned KCHAR_W     = 8;

  localparam logic [KCHAR_W-1:0] K28_5 = 8'hBC;
  localparam logic [KCHAR_W-1:0] K28_1 = 8'h3C;
  localparam logic [KCHAR_W-1:0] K23_7 = 8'hF7;
  localparam logic [KCHAR_W-1:0] K27_7 = 8'hFB;

  typedef enum logic [PHASE_W-1:0] {
    PH_W0 = 2'd0,
    PH_W1 = 2'd1,
    PH_W2 = 2'd2,
    PH_W3 = 2'd3
  } phase_e;

  // Frame-start K-char: resync > bc0 > overflow > idle; TTC chars can be masked off.
  function automatic logic [KCHAR_W-1:0] kchar_sel(
    input logic               resync,
    input logic               bc0,
    input logic               overflow,
    input logic               allow_ttc,
    input logic [KCHAR_W-1:0] idle_k
  );
    if (allow_ttc && resync) begin
      kchar_sel = K28_1;
    end else if (allow_ttc && bc0) begin
      kchar_sel = K23_7;
    end else if (overflow) begin
      kchar_sel = K27_7;
    end else begin
      kchar_sel = idle_k;
    end
  endfunction

endpackage

// File: rtl/gem_frame_word_mux.sv
// Selects one 16-bit link word and its charisk from a 56-bit payload.
// Ports: payload_i (56b payload), kchar_i (frame-start K-char),
//        phase_i (word index 0..3), word_c / isk_c (combinational word, charisk).
module gem_frame_word_mux
  import gem_link_pkg::*;
(
  input  logic [PAYLOAD_W-1:0] payload_i,
  input  logic [KCHAR_W-1:0]   kchar_i,
  input  logic [PHASE_W-1:0]   phase_i,
  output logic [WORD_W-1:0]    word_c,
  output logic [ISK_W-1:0]     isk_c
);

  // Word 0 carries the K-char in its low byte, flagged by isk bit 0.
  always_comb begin
    word_c = '0;
    isk_c  = 2'b00;
    case (phase_i)
      PH_W0: begin
        word_c = {payload_i[7:0], kchar_i};
        isk_c  = 2'b01;
      end
      PH_W1:   word_c = payload_i[23:8];
      PH_W2:   word_c = payload_i[39:24];
      default: word_c = payload_i[55:40];
    endcase
  end

endmodule

// File: rtl/gem_trig_frame_gen.sv
// GEM trigger optical-link frame generator (160 MHz).
// Latches one BX of cluster data on bx_strobe_i and serialises each link's
// 56-bit payload as four 16-bit words; word 0 carries a frame-start K-char
// encoding resync/BC0/overflow. Early strobes abort the frame and are counted;
// a missing strobe produces an idle frame.
// Ports: clock_160/reset_i (async, active high); bx_strobe_i, gem_data_i,
//        overflow_i, bxn_lsbs_i, bc0_i, resync_i, ready_i (BX inputs);
//        tx_data_{a,b}_o / tx_isk_{a,b}_o (link words), frame_phase_o,
//        misalign_cnt_o (saturating early-strobe count), bxn_err_o.
// Optional: define GEM_FRAME_BXN_CHECK_EN to build the sticky BX-sequence
// checker behind bxn_err_o; otherwise bxn_err_o is tied low.
module gem_trig_frame_gen
  import gem_link_pkg::*;
#(
  parameter int unsigned        ALLOW_TTC_CHARS = 1,
  parameter logic [KCHAR_W-1:0] IDLE_KCHAR      = K28_5,
  parameter int unsigned        MISALIGN_CNT_W  = 8
) (
  input  logic                      clock_160,
  input  logic                      reset_i,
  input  logic                      bx_strobe_i,
  input  logic [2*PAYLOAD_W-1:0]    gem_data_i,
  input  logic                      overflow_i,
  input  logic [1:0]                bxn_lsbs_i,
  input  logic                      bc0_i,
  input  logic                      resync_i,
  input  logic                      ready_i,
  output logic [WORD_W-1:0]         tx_data_a_o,
  output logic [ISK_W-1:0]          tx_isk_a_o,
  output logic [WORD_W-1:0]         tx_data_b_o,
  output logic [ISK_W-1:0]          tx_isk_b_o,
  output logic [PHASE_W-1:0]        frame_phase_o,
  output logic [MISALIGN_CNT_W-1:0] misalign_cnt_o,
  output logic                      bxn_err_o
);

  localparam logic ALLOW_TTC = (ALLOW_TTC_CHARS != 0);

  phase_e                    phase_q, phase_d;
  logic [PAYLOAD_W-1:0]      pay_a_q, pay_a_d;
  logic [PAYLOAD_W-1:0]      pay_b_q, pay_b_d;
  logic [KCHAR_W-1:0]        kchar_q, kchar_d;
  logic [MISALIGN_CNT_W-1:0] misalign_q, misalign_d;
  logic [WORD_W-1:0]         tx_data_a_q, tx_data_a_d;
  logic [WORD_W-1:0]         tx_data_b_q, tx_data_b_d;
  logic [ISK_W-1:0]          tx_isk_a_q, tx_isk_a_d;
  logic [ISK_W-1:0]          tx_isk_b_q, tx_isk_b_d;

  // Frame sequencing: a strobe restarts at word 0 (counting it if early);
  // otherwise advance, rolling into an idle frame after word 3.
  always_comb begin
    phase_d    = phase_q;
    pay_a_d    = pay_a_q;
    pay_b_d    = pay_b_q;
    kchar_d    = kchar_q;
    misalign_d = misalign_q;
    if (bx_strobe_i) begin
      phase_d = PH_W0;
      if ((phase_q != PH_W3) && (misalign_q != {MISALIGN_CNT_W{1'b1}})) begin
        misalign_d = misalign_q + MISALIGN_CNT_W'(1);
      end
      if (ready_i) begin
        pay_a_d = gem_data_i[PAYLOAD_W-1:0];
        pay_b_d = gem_data_i[2*PAYLOAD_W-1:PAYLOAD_W];
        kchar_d = kchar_sel(resync_i, bc0_i, overflow_i, ALLOW_TTC, IDLE_KCHAR);
      end else begin
        pay_a_d = '0;
        pay_b_d = '0;
        kchar_d = IDLE_KCHAR;
      end
    end else if (phase_q == PH_W3) begin
      phase_d = PH_W0;
      pay_a_d = '0;
      pay_b_d = '0;
      kchar_d = IDLE_KCHAR;
    end else begin
      phase_d = phase_e'(PHASE_W'(phase_q) + PHASE_W'(1));
    end
  end

  // Words are built from next-state values so word 0 registers on the strobe edge.
  gem_frame_word_mux u_mux_a (
    .payload_i (pay_a_d),
    .kchar_i   (kchar_d),
    .phase_i   (PHASE_W'(phase_d)),
    .word_c    (tx_data_a_d),
    .isk_c     (tx_isk_a_d)
  );

  gem_frame_word_mux u_mux_b (
    .payload_i (pay_b_d),
    .kchar_i   (kchar_d),
    .phase_i   (PHASE_W'(phase_d)),
    .word_c    (tx_data_b_d),
    .isk_c     (tx_isk_b_d)
  );

  always_ff @(posedge clock_160 or posedge reset_i) begin
    if (reset_i) begin
      phase_q     <= PH_W3;
      pay_a_q     <= '0;
      pay_b_q     <= '0;
      kchar_q     <= '0;
      misalign_q  <= '0;
      tx_data_a_q <= '0;
      tx_data_b_q <= '0;
      tx_isk_a_q  <= '0;
      tx_isk_b_q  <= '0;
    end else begin
      phase_q     <= phase_d;
      pay_a_q     <= pay_a_d;
      pay_b_q     <= pay_b_d;
      kchar_q     <= kchar_d;
      misalign_q  <= misalign_d;
      tx_data_a_q <= tx_data_a_d;
      tx_data_b_q <= tx_data_b_d;
      tx_isk_a_q  <= tx_isk_a_d;
      tx_isk_b_q  <= tx_isk_b_d;
    end
  end

  assign tx_data_a_o    = tx_data_a_q;
  assign tx_isk_a_o     = tx_isk_a_q;
  assign tx_data_b_o    = tx_data_b_q;
  assign tx_isk_b_o     = tx_isk_b_q;
  assign frame_phase_o  = PHASE_W'(phase_q);
  assign misalign_cnt_o = misalign_q;

`ifdef GEM_FRAME_BXN_CHECK_EN
  logic [1:0] bxn_exp_q, bxn_exp_d;
  logic       bxn_vld_q, bxn_vld_d;
  logic       bxn_err_q, bxn_err_d;

  // Expected BX LSBs track strobe to strobe; resync clears the error and only reloads.
  always_comb begin
    bxn_exp_d = bxn_exp_q;
    bxn_vld_d = bxn_vld_q;
    bxn_err_d = bxn_err_q;
    if (bx_strobe_i) begin
      bxn_exp_d = bxn_lsbs_i + 2'd1;
      bxn_vld_d = 1'b1;
      if (resync_i) begin
        bxn_err_d = 1'b0;
      end else if (bxn_vld_q && (bxn_lsbs_i != bxn_exp_q)) begin
        bxn_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock_160 or posedge reset_i) begin
    if (reset_i) begin
      bxn_exp_q <= '0;
      bxn_vld_q <= 1'b0;
      bxn_err_q <= 1'b0;
    end else begin
      bxn_exp_q <= bxn_exp_d;
      bxn_vld_q <= bxn_vld_d;
      bxn_err_q <= bxn_err_d;
    end
  end

  assign bxn_err_o = bxn_err_q;
`else
  logic unused_bxn;
  assign unused_bxn = ^bxn_lsbs_i;
  assign bxn_err_o  = 1'b0;
`endif

endmodule
